// File: rtl/sample_capture_pkg.sv
// Shared types and constants for the sample capture writer.
package sample_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FLUSH   = 2'd2
    } state_e;

    localparam logic [3:0] BE_FULL          = 4'hF;
    localparam logic [3:0] BE_LOW           = 4'h3;
    localparam int         SAMPLES_PER_WORD = 2;
    localparam int         SAMPLE_W         = 32 / SAMPLES_PER_WORD;

endpackage

// File: rtl/sample_packer.sv
// Packs two consecutive accepted samples into one 32-bit word, low half first.
module sample_packer
    import sample_capture_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                accept,
    input  logic [SAMPLE_W-1:0] sample,
    output logic [31:0]         word,
    output logic                word_ready,
    output logic                half,
    output logic [31:0]         flush_word
);

    logic        half_q, half_d;
    logic        ready_q, ready_d;
    logic [31:0] word_q, word_d;

    // Steer each accepted sample into the half selected by the half flag.
    always_comb begin
        half_d  = half_q;
        word_d  = word_q;
        ready_d = 1'b0;
        if (clear) begin
            half_d = 1'b0;
        end else if (accept) begin
            half_d  = ~half_q;
            ready_d = half_q;
            if (half_q) begin
                word_d[2*SAMPLE_W-1:SAMPLE_W] = sample;
            end else begin
                word_d[SAMPLE_W-1:0] = sample;
            end
        end
    end

    // Packing state registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            half_q  <= 1'b0;
            ready_q <= 1'b0;
            word_q  <= '0;
        end else begin
            half_q  <= half_d;
            ready_q <= ready_d;
            word_q  <= word_d;
        end
    end

    assign word       = word_q;
    assign word_ready = ready_q;
    assign half       = half_q;
    assign flush_word = {16'h0, word_q[SAMPLE_W-1:0]};

endmodule

// File: rtl/sample_capture_writer.sv
// Capture control: packs the sample stream into words and writes them to
// sequential memory addresses in one-shot or circular mode.
module sample_capture_writer
    import sample_capture_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              circular,
    input  logic [ADDR_W:0]   len_words,
    input  logic              snk_valid,
    input  logic [15:0]       snk_data,
    output logic              snk_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    output logic              busy,
    output logic              done,
    output logic              wrapped,
    output logic [ADDR_W:0]   wr_count
);

    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              circ_q, circ_d;
    logic              wrapped_q, wrapped_d;
    logic              done_q, done_d;

    logic [31:0]       pk_word, pk_flush_word;
    logic              pk_word_ready, pk_half;
    logic              accept, start_go, full_wr, flush_wr, at_last, last_pending;
    logic [ADDR_W:0]   len_clamped;

    assign start_go     = (state_q == IDLE) && start;
    assign full_wr      = (state_q == CAPTURE) && pk_word_ready;
    assign flush_wr     = (state_q == FLUSH);
    assign at_last      = ({1'b0, ptr_q} == (len_q - 1'b1));
    // The final one-shot word is on the bus: stop accepting before it lands.
    assign last_pending = full_wr && !circ_q && at_last;
    assign accept       = snk_valid && snk_ready;
    assign len_clamped  = ((len_words == '0) || (len_words > DEPTH_L)) ? DEPTH_L : len_words;

    sample_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (start_go || flush_wr),
        .accept     (accept),
        .sample     (snk_data),
        .word       (pk_word),
        .word_ready (pk_word_ready),
        .half       (pk_half),
        .flush_word (pk_flush_word)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: abort beats a same-cycle sample; a half word forces a flush.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (abort) begin
                    state_d = pk_half ? FLUSH : IDLE;
                end else if (last_pending) begin
                    state_d = IDLE;
                end
            end
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs and memory strobe decode.
    always_comb begin
        snk_ready      = (state_q == CAPTURE) && !abort && !last_pending;
        busy           = (state_q != IDLE);
        mem_write      = full_wr || flush_wr;
        mem_chipselect = full_wr || flush_wr;
        mem_byteenable = 4'h0;
        mem_writedata  = 32'h0;
        if (full_wr) begin
            mem_byteenable = BE_FULL;
            mem_writedata  = pk_word;
        end else if (flush_wr) begin
            mem_byteenable = BE_LOW;
            mem_writedata  = pk_flush_word;
        end
    end

    // Pointer, word count, wrap flag and the end-of-capture pulse.
    always_comb begin
        ptr_d     = ptr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        circ_d    = circ_q;
        wrapped_d = wrapped_q;
        done_d    = (state_q != IDLE) && (state_d == IDLE);
        if (start_go) begin
            circ_d    = circular;
            len_d     = len_clamped;
            cnt_d     = '0;
            ptr_d     = '0;
            wrapped_d = 1'b0;
        end
        if (full_wr || flush_wr) begin
            cnt_d = (cnt_q == DEPTH_L) ? cnt_q : cnt_q + 1'b1;
        end
        if (full_wr) begin
            if (at_last) begin
                ptr_d = '0;
                if (circ_q) wrapped_d = 1'b1;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    // Capture bookkeeping registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            circ_q    <= 1'b0;
            wrapped_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            circ_q    <= circ_d;
            wrapped_q <= wrapped_d;
            done_q    <= done_d;
        end
    end

    assign mem_address = ptr_q;
    assign mem_clken   = 1'b1;
    assign done        = done_q;
    assign wrapped     = wrapped_q;
    assign wr_count    = cnt_q;

endmodule

// File: tb/tb_sample_capture_writer.sv
// Directed and randomized bench for sample_capture_writer.
module tb_sample_capture_writer;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    logic              clk = 1'b0;
    logic              reset_n, start, abort, circular;
    logic [ADDR_W:0]   len_words;
    logic              snk_valid;
    logic [15:0]       snk_data;
    logic              snk_ready;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect, mem_write, mem_clken;
    logic [31:0]       mem_writedata;
    logic              busy, done, wrapped;
    logic [ADDR_W:0]   wr_count;

    sample_capture_writer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .circular(circular), .len_words(len_words),
        .snk_valid(snk_valid), .snk_data(snk_data), .snk_ready(snk_ready),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .busy(busy), .done(done), .wrapped(wrapped), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Observed write log and reference sample stream.
    logic [ADDR_W-1:0] w_addr[$];
    logic [31:0]       w_data[$];
    logic [3:0]        w_be[$];
    logic              w_wrap[$];
    logic              w_rdy[$];
    logic              w_cs[$];
    logic [ADDR_W:0]   w_cnt[$];
    int                w_cyc[$];
    int                done_cyc[$];
    logic [15:0]       sent[$];

    always @(negedge clk) begin
        if (reset_n && mem_write) begin
            w_addr.push_back(mem_address);
            w_data.push_back(mem_writedata);
            w_be.push_back(mem_byteenable);
            w_wrap.push_back(wrapped);
            w_rdy.push_back(snk_ready);
            w_cs.push_back(mem_chipselect);
            w_cnt.push_back(wr_count);
            w_cyc.push_back(cyc);
        end
        if (reset_n && done) done_cyc.push_back(cyc);
        cyc = cyc + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_outs"}, {snk_ready, mem_address, mem_byteenable, mem_chipselect,
                             mem_write, mem_writedata, busy, done, wrapped, wr_count}, 64'h0);
        chk({tag, "_clken"}, mem_clken, 1);
    endtask

    task automatic begin_capture(input bit circ, input logic [ADDR_W:0] len);
        w_addr.delete(); w_data.delete(); w_be.delete(); w_wrap.delete();
        w_rdy.delete(); w_cs.delete(); w_cnt.delete(); w_cyc.delete();
        done_cyc.delete(); sent.delete();
        circular  = circ;
        len_words = len;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        circular  = 1'b0;
        len_words = '0;
    endtask

    // Offer n samples with optional random gaps; optionally pulse start throughout.
    task automatic send(input int n, input logic [15:0] base, input bit rnd,
                        input int gapmax, input bit noise);
        bit          acc;
        int          guard;
        int          g;
        logic [15:0] v;
        for (int i = 0; i < n; i++) begin
            v = rnd ? 16'($urandom) : base + 16'(i);
            if (gapmax > 0) begin
                g = $urandom_range(0, gapmax);
                snk_valid = 1'b0;
                repeat (g) begin
                    start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                    tick();
                end
            end
            snk_valid = 1'b1;
            snk_data  = v;
            acc       = 1'b0;
            guard     = 0;
            while (!acc && guard < 50) begin
                if (noise) start = 1'($urandom_range(0, 1));
                @(negedge clk);
                acc = snk_ready;
                tick();
                guard++;
            end
            if (!acc) begin
                n_cmp++;
                n_err++;
                $error("FAIL accept_timeout observed=no_ready expected=ready sample=%0d", i);
            end
            sent.push_back(v);
        end
        snk_valid = 1'b0;
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int guard = 0;
        while (done_cyc.size() == 0 && guard < 20) begin
            tick();
            guard++;
        end
        tick();
        tick();
        chk({tag, "_done_count"}, done_cyc.size(), 1);
        chk({tag, "_busy_after"}, busy, 0);
    endtask

    task automatic chk_done_timing(input string tag);
        if (done_cyc.size() > 0 && w_cyc.size() > 0) begin
            chk({tag, "_done_lat"}, done_cyc[0], w_cyc[w_cyc.size()-1] + 1);
        end else begin
            n_cmp++;
            n_err++;
            $error("FAIL %s_done_lat observed=missing expected=present", tag);
        end
    endtask

    // Reference: consecutive sample pairs fill words at addresses k mod len.
    task automatic check_writes(input string tag, input int len_eff, input bit circ,
                                input bit flush);
        int          nexp;
        logic [31:0] ed;
        logic [3:0]  eb;
        nexp = sent.size() / 2 + ((flush && (sent.size() % 2 == 1)) ? 1 : 0);
        chk({tag, "_nwrites"}, w_addr.size(), nexp);
        if (w_addr.size() == nexp) begin
            for (int k = 0; k < nexp; k++) begin
                if (2*k + 1 < sent.size()) begin
                    ed = {sent[2*k+1], sent[2*k]};
                    eb = 4'hF;
                end else begin
                    ed = {16'h0, sent[2*k]};
                    eb = 4'h3;
                end
                chk($sformatf("%s_addr%0d", tag, k), w_addr[k], k % len_eff);
                chk($sformatf("%s_data%0d", tag, k), w_data[k], ed);
                chk($sformatf("%s_be%0d", tag, k), w_be[k], eb);
                chk($sformatf("%s_cs%0d", tag, k), w_cs[k], 1);
                chk($sformatf("%s_wrap%0d", tag, k), w_wrap[k], (circ && k >= len_eff) ? 1 : 0);
                chk($sformatf("%s_cnt%0d", tag, k), w_cnt[k], (k < DEPTH) ? k : DEPTH);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; circular = 1'b0;
        len_words = '0; snk_valid = 1'b0; snk_data = '0;
        tick();
        tick();
        chk_idle_outs("reset");
        reset_n = 1'b1;
        tick();

        // abort while idle does nothing
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        tick();
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_done", done_cyc.size(), 0);

        // one-shot, four words, back-to-back samples 1..8
        begin_capture(1'b0, 11'd4);
        chk("oneshot_busy", busy, 1);
        chk("oneshot_ready", snk_ready, 1);
        send(8, 16'h0001, 1'b0, 0, 1'b0);
        wait_done("oneshot");
        check_writes("oneshot", 4, 1'b0, 1'b0);
        chk_done_timing("oneshot");
        chk("oneshot_wr_count", wr_count, 4);
        if (w_data.size() == 4) chk("oneshot_word3", w_data[3], 32'h00080007);
        if (w_rdy.size() == 4) chk("oneshot_ready_last", w_rdy[3], 0);

        // abort with a half word pending flushes it
        begin_capture(1'b0, 11'd8);
        send(3, 16'h0001, 1'b0, 0, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done("flush");
        check_writes("flush", 8, 1'b0, 1'b1);
        chk_done_timing("flush");
        chk("flush_wr_count", wr_count, 2);

        // abort on a full-word strobe cycle: the write completes, the sample is refused
        begin_capture(1'b0, 11'd8);
        send(2, 16'h0011, 1'b0, 0, 1'b0);
        abort     = 1'b1;
        snk_valid = 1'b1;
        snk_data  = 16'h0033;
        tick();
        abort     = 1'b0;
        snk_valid = 1'b0;
        wait_done("pend");
        check_writes("pend", 8, 1'b0, 1'b0);
        chk("pend_wr_count", wr_count, 1);

        // circular, two words, ten samples
        begin_capture(1'b1, 11'd2);
        send(10, 16'h0100, 1'b0, 0, 1'b0);
        tick();
        check_writes("circ", 2, 1'b1, 1'b0);
        chk("circ_busy", busy, 1);
        chk("circ_wrapped", wrapped, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done("circ");
        chk("circ_wrapped_sticky", wrapped, 1);
        chk("circ_wr_count", wr_count, 5);

        // len_words = 0 means full depth
        begin_capture(1'b0, 11'd0);
        send(2048, 16'h1000, 1'b0, 0, 1'b0);
        wait_done("full");
        check_writes("full", DEPTH, 1'b0, 1'b0);
        chk_done_timing("full");
        chk("full_wr_count", wr_count, 1024);
        if (w_addr.size() > 0) chk("full_last_addr", w_addr[w_addr.size()-1], 10'h3FF);

        // oversize length clamps to depth; circular count saturates
        begin_capture(1'b1, 11'd1500);
        send(2052, 16'h0000, 1'b1, 0, 1'b0);
        tick();
        check_writes("sat", DEPTH, 1'b1, 1'b0);
        chk("sat_wr_count", wr_count, 1024);
        chk("sat_wrapped", wrapped, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done("sat");

        // reset mid-capture with a half word pending: no flush, clean restart
        begin_capture(1'b0, 11'd8);
        send(3, 16'h0051, 1'b0, 0, 1'b0);
        reset_n = 1'b0;
        tick();
        chk_idle_outs("midreset");
        reset_n = 1'b1;
        repeat (4) tick();
        chk("midreset_nwrites", w_addr.size(), 1);
        chk("midreset_done", done_cyc.size(), 0);
        begin_capture(1'b0, 11'd8);
        send(2, 16'h000A, 1'b0, 0, 1'b0);
        tick();
        check_writes("restart", 8, 1'b0, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done("restart");

        // random samples with random gaps and start pulses while busy
        begin_capture(1'b0, 11'd6);
        send(12, 16'h0, 1'b1, 3, 1'b1);
        wait_done("rand");
        check_writes("rand", 6, 1'b0, 1'b0);
        chk_done_timing("rand");
        chk("rand_wr_count", wr_count, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
